// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the serial detector blocks
package serial_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/serial_pattern_window.sv
// rtl/serial_pattern_window.sv - sliding bit window with pattern comparator
module serial_pattern_window #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b111
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic din,
    output logic match
);

    // Only the PAT_LEN-1 older bits need storing; the newest bit is din itself.
    localparam int HW = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;

    logic [HW-1:0]      hist;
    logic [PAT_LEN-1:0] window_nxt;

    generate
        if (PAT_LEN == 1) begin : g_single
            assign window_nxt = din;
        end else begin : g_multi
            assign window_nxt = {hist, din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= window_nxt[HW-1:0];
        end
    end

    assign match = (window_nxt == PATTERN);

endmodule

// File: rtl/serial_frame_monitor.sv
// rtl/serial_frame_monitor.sv - frames a serial bitstream, counts pattern hits per frame
// and reports the count over a valid/ready handshake with a sticky alarm.
module serial_frame_monitor
    import serial_pkg::*;
#(
    parameter int                 FRAME_LEN    = 8,
    parameter int                 PAT_LEN      = 3,
    parameter logic [PAT_LEN-1:0] PATTERN      = 3'b111,
    parameter int                 CNT_W        = 4,
    parameter int                 ALARM_THRESH = 1,
    parameter bit                 AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             pattern_hit,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic             alarm,
    input  logic             clear_alarm
);

    localparam int BW = $clog2(FRAME_LEN + 1);

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_nxt;
    logic          accept;
    logic          handshake;
    logic          frame_start;
    logic          win_match;
    logic          is_hit;
    logic          last_bit;

    assign accept      = (state == ST_RUN) && din_valid;
    assign handshake   = (state == ST_REPORT) && frame_ready;
    assign frame_start = ((state == ST_IDLE) && start) || (handshake && AUTO_RESTART);
    assign bit_cnt_nxt = bit_cnt + BW'(1);
    // Early bits of a frame cannot match: the window still holds cleared history.
    assign is_hit      = accept && win_match && (bit_cnt_nxt >= BW'(PAT_LEN));
    assign last_bit    = (bit_cnt_nxt == BW'(FRAME_LEN));

    serial_pattern_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_start),
        .shift_en (accept),
        .din      (din),
        .match    (win_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            hit_count   <= '0;
            pattern_hit <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            pattern_hit <= is_hit;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        hit_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        bit_cnt <= bit_cnt_nxt;
                        if (is_hit && (hit_count != {CNT_W{1'b1}})) begin
                            hit_count <= hit_count + CNT_W'(1);
                        end
                        if (last_bit) begin
                            state       <= ST_REPORT;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        if (AUTO_RESTART) begin
                            state     <= ST_RUN;
                            bit_cnt   <= '0;
                            hit_count <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

    // A setting handshake beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (handshake && (int'(hit_count) >= ALARM_THRESH)) begin
            alarm <= 1'b1;
        end else if (clear_alarm) begin
            alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_monitor.sv
// tb/tb_serial_frame_monitor.sv - bench for serial_frame_monitor (default and 16-bit/auto-restart configs)
module tb_serial_frame_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_start = 1'b0, a_din = 1'b0, a_dv = 1'b0, a_rdy = 1'b0, a_clr = 1'b0;
    logic       a_busy, a_ph, a_fv, a_al;
    logic [3:0] a_hc;
    logic       b_rst = 1'b1, b_start = 1'b0, b_din = 1'b0, b_dv = 1'b0, b_rdy = 1'b0, b_clr = 1'b0;
    logic       b_busy, b_ph, b_fv, b_al;
    logic [1:0] b_hc;

    serial_frame_monitor dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .din(a_din), .din_valid(a_dv),
        .busy(a_busy), .pattern_hit(a_ph), .frame_valid(a_fv), .frame_ready(a_rdy),
        .hit_count(a_hc), .alarm(a_al), .clear_alarm(a_clr)
    );

    serial_frame_monitor #(
        .FRAME_LEN(16), .PAT_LEN(3), .PATTERN(3'b111), .CNT_W(2), .ALARM_THRESH(2), .AUTO_RESTART(1'b1)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .din(b_din), .din_valid(b_dv),
        .busy(b_busy), .pattern_hit(b_ph), .frame_valid(b_fv), .frame_ready(b_rdy),
        .hit_count(b_hc), .alarm(b_al), .clear_alarm(b_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the frame is kept as a plain list of accepted bits and the
    // hit count is recounted from scratch over every window position.
    int p_flen[2] = '{8, 16};
    int p_plen[2] = '{3, 3};
    int p_pat[2]  = '{7, 7};
    int p_cmax[2] = '{15, 3};
    int p_thr[2]  = '{1, 2};
    int p_auto[2] = '{0, 1};
    int m_st[2], m_n[2], m_hits[2], m_phit[2], m_alarm[2];
    int m_bits[2][256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int win_at(input int k, input int i);
        int v = 0;
        for (int j = 0; j < p_plen[k]; j++) v = (v << 1) | m_bits[k][i - p_plen[k] + 1 + j];
        return v;
    endfunction

    function automatic int count_hits(input int k);
        int c = 0;
        for (int i = p_plen[k] - 1; i < m_n[k]; i++) if (win_at(k, i) == p_pat[k]) c++;
        return (c > p_cmax[k]) ? p_cmax[k] : c;
    endfunction

    task automatic model_step(input int k, input logic rst, input logic st, input logic din,
                              input logic dv, input logic rdy, input logic clr);
        int al;
        if (rst) begin
            m_st[k] = 0; m_n[k] = 0; m_hits[k] = 0; m_phit[k] = 0; m_alarm[k] = 0;
            return;
        end
        al = m_alarm[k];
        if (m_st[k] == 2 && rdy && m_hits[k] >= p_thr[k]) al = 1;
        else if (clr) al = 0;
        m_phit[k] = 0;
        case (m_st[k])
            0: if (st) begin m_st[k] = 1; m_n[k] = 0; m_hits[k] = 0; end
            1: if (dv) begin
                m_bits[k][m_n[k]] = int'(din);
                m_n[k]++;
                m_hits[k] = count_hits(k);
                m_phit[k] = (m_n[k] >= p_plen[k] && win_at(k, m_n[k] - 1) == p_pat[k]) ? 1 : 0;
                if (m_n[k] == p_flen[k]) m_st[k] = 2;
            end
            default: if (rdy) begin
                if (p_auto[k] != 0) begin m_st[k] = 1; m_n[k] = 0; m_hits[k] = 0; end
                else m_st[k] = 0;
            end
        endcase
        m_alarm[k] = al;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, a_rst, a_start, a_din, a_dv, a_rdy, a_clr);
        model_step(1, b_rst, b_start, b_din, b_dv, b_rdy, b_clr);
        @(negedge clk);
        chk("A.busy", a_busy, m_st[0] != 0);
        chk("A.frame_valid", a_fv, m_st[0] == 2);
        chk("A.pattern_hit", a_ph, m_phit[0]);
        chk("A.hit_count", a_hc, m_hits[0]);
        chk("A.alarm", a_al, m_alarm[0]);
        chk("B.busy", b_busy, m_st[1] != 0);
        chk("B.frame_valid", b_fv, m_st[1] == 2);
        chk("B.pattern_hit", b_ph, m_phit[1]);
        chk("B.hit_count", b_hc, m_hits[1]);
        chk("B.alarm", b_al, m_alarm[1]);
    endtask

    task automatic a_feed(input logic [15:0] bits, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            a_din = bits[j]; a_dv = 1'b1; cycle();
        end
        a_dv = 1'b0; a_din = 1'b0;
    endtask

    task automatic a_go();
        a_start = 1'b1; cycle(); a_start = 1'b0;
    endtask

    task automatic a_hs();
        a_rdy = 1'b1; cycle(); a_rdy = 1'b0;
    endtask

    typedef struct packed {
        logic rst, start, din, dv, rdy, clr;
        logic busy, fv, ph;
        logic [3:0] hc;
        logic al;
    } vec_t;

    function automatic vec_t mk(input logic rst, start, din, dv, rdy, clr, busy, fv, ph,
                                input logic [3:0] hc, input logic al);
        vec_t v;
        v = {rst, start, din, dv, rdy, clr, busy, fv, ph, hc, al};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int   acc;
        logic got;
        logic ph_seen;

        // rst start din dv rdy clr | busy fv ph hc al
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 2, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            {a_rst, a_start, a_din, a_dv, a_rdy, a_clr} =
                {tbl[i].rst, tbl[i].start, tbl[i].din, tbl[i].dv, tbl[i].rdy, tbl[i].clr};
            cycle();
            b_rst = 1'b0;
            chk($sformatf("tbl[%0d].busy", i), a_busy, tbl[i].busy);
            chk($sformatf("tbl[%0d].frame_valid", i), a_fv, tbl[i].fv);
            chk($sformatf("tbl[%0d].pattern_hit", i), a_ph, tbl[i].ph);
            chk($sformatf("tbl[%0d].hit_count", i), a_hc, tbl[i].hc);
            chk($sformatf("tbl[%0d].alarm", i), a_al, tbl[i].al);
        end
        {a_rst, a_start, a_din, a_dv, a_rdy, a_clr} = '0;

        // Overlapping hits, then frames whose tails must not join the next frame.
        a_go(); a_feed(16'b11111000, 8);
        chk("t2_overlap_hc", a_hc, 3);
        chk("t2_overlap_fv", a_fv, 1);
        a_hs();
        chk("t2_alarm", a_al, 1);
        a_go(); a_feed(16'b00000011, 8);
        chk("t2_tail_hc", a_hc, 0);
        a_hs();
        a_go();
        ph_seen = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            a_din = (j == 7); a_dv = 1'b1; cycle(); ph_seen |= a_ph;
        end
        a_dv = 1'b0; a_din = 1'b0;
        chk("t2_nospan_ph", ph_seen, 0);
        chk("t2_nospan_hc", a_hc, 0);
        a_hs();

        // Reset in the middle of a frame.
        a_go(); a_feed(16'b1111, 4);
        chk("t5_mid_hc", a_hc, 2);
        chk("t5_mid_alarm", a_al, 1);
        a_rst = 1'b1; cycle(); a_rst = 1'b0;
        chk("t5_rst_hc", a_hc, 0);
        chk("t5_rst_alarm", a_al, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_fv", a_fv, 0);
        a_go(); a_feed(16'b0, 8);
        chk("t5_zero_fv", a_fv, 1);
        chk("t5_zero_hc", a_hc, 0);
        a_hs();
        chk("t5_idle_busy", a_busy, 0);

        // Saturation and set-beats-clear on the 16-bit auto-restart instance.
        b_start = 1'b1; cycle(); b_start = 1'b0;
        for (int j = 0; j < 16; j++) begin b_din = 1'b1; b_dv = 1'b1; cycle(); end
        b_dv = 1'b0; b_din = 1'b0;
        chk("t4_sat_hc", b_hc, 3);
        chk("t4_sat_fv", b_fv, 1);
        b_rdy = 1'b1; b_clr = 1'b1; cycle(); b_rdy = 1'b0; b_clr = 1'b0;
        chk("t4_set_wins", b_al, 1);
        chk("t4_restart_busy", b_busy, 1);
        chk("t4_restart_fv", b_fv, 0);
        chk("t4_restart_hc", b_hc, 0);

        // Two back-to-back frames without start, din_valid toggling.
        for (int f = 0; f < 2; f++) begin
            acc = 0; got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                b_dv = (c % 2 == 0); b_din = 1'b0;
                cycle();
                if (b_dv) acc++;
                if (b_fv) got = 1'b1;
            end
            b_dv = 1'b0;
            chk($sformatf("t6_frame%0d_seen", f), got, 1);
            chk($sformatf("t6_frame%0d_bits", f), acc, 16);
            b_rdy = 1'b1; cycle(); b_rdy = 1'b0;
        end

        // Random traffic on both instances against the model.
        a_rst = 1'b1; b_rst = 1'b1; cycle();
        for (int i = 0; i < 3000; i++) begin
            a_rst = ($urandom_range(0, 199) == 0);
            a_start = ($urandom_range(0, 3) == 0);
            a_din = $urandom_range(0, 1);
            a_dv = ($urandom_range(0, 3) != 0);
            a_rdy = $urandom_range(0, 1);
            a_clr = ($urandom_range(0, 15) == 0);
            b_rst = ($urandom_range(0, 199) == 0);
            b_start = ($urandom_range(0, 3) == 0);
            b_din = ($urandom_range(0, 3) != 0);
            b_dv = ($urandom_range(0, 3) != 0);
            b_rdy = $urandom_range(0, 1);
            b_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
